// File: rtl/bit_serial_adder.sv
// bit_serial_adder: LSB-first serial adder, one bit per clock through a single sum/carry cell
// Ports: clk, rst_n (sync, active-low), start/a/b load operands in IDLE or DONE,
// busy is high while bits are being added, done pulses for one cycle when sum/cout update,
// sum/cout hold the last completed result.
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] sa, sb, r, r_next;
  logic [WIDTH:0] rr;
  logic [CW-1:0] cnt;
  logic c, s, c_next;
  always_comb begin
    s = sa[0] ^ sb[0] ^ c;
    c_next = (sa[0] & sb[0]) | (c & (sa[0] ^ sb[0]));
    rr = {s, r};
    r_next = rr[WIDTH:1];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      sum <= '0;
      cout <= 1'b0;
      sa <= '0;
      sb <= '0;
      r <= '0;
      c <= 1'b0;
      cnt <= '0;
    end else begin
      done <= 1'b0;
      if (state == RUN) begin
        sa <= sa >> 1;
        sb <= sb >> 1;
        r <= r_next;
        c <= c_next;
        cnt <= cnt + 1'b1;
        // last bit: publish the result and its final carry
        if (cnt == CW'(WIDTH - 1)) begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
          sum <= r_next;
          cout <= c_next;
        end
      end else if (start) begin
        state <= RUN;
        busy <= 1'b1;
        sa <= a;
        sb <= b;
        r <= '0;
        c <= 1'b0;
        cnt <= '0;
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_bit_serial_adder.sv
// tb_bit_serial_adder: random and directed checks of bit_serial_adder at WIDTH 1, 8 and 16
module tb_bit_serial_adder;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic st1 = 0, st8 = 0, st16 = 0;
  logic [0:0] a1 = 0, b1 = 0, sum1;
  logic [7:0] a8 = 0, b8 = 0, sum8;
  logic [15:0] a16 = 0, b16 = 0, sum16;
  logic busy1, done1, cout1, busy8, done8, cout8, busy16, done16, cout16;
  int total = 0, bad = 0;
  logic [8:0] hold8 = 0;
  logic [16:0] hold16 = 0;

  bit_serial_adder #(.WIDTH(1)) u1 (.clk(clk), .rst_n(rst_n), .start(st1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));
  bit_serial_adder #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .start(st8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));
  bit_serial_adder #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .start(st16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 0;
    tick;
    tick;
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      tick;
      total++;
      if ({busy8, done8, cout8, sum8} !== 11'h0) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got busy=%b done=%b cout=%b sum=%h want all 0", i, busy8, done8, cout8, sum8);
      end
    end
    total++;
    if ({busy1, done1, cout1, sum1, busy16, done16, cout16, sum16} !== 23'h0) begin
      bad++;
      $display("FAIL reset_other got w1=%b%b%b%b w16=%b%b%b%h want zeros", busy1, done1, cout1, sum1, busy16, done16, cout16, sum16);
    end
    hold8 = 0;
    hold16 = 0;
  endtask

  task automatic op8(input logic [7:0] x, input logic [7:0] y, input string nm);
    logic [8:0] e;
    e = {1'b0, x} + {1'b0, y};
    a8 = x;
    b8 = y;
    st8 = 1;
    tick;
    st8 = 0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (busy8 !== 1 || done8 !== 0 || {cout8, sum8} !== hold8) begin
        bad++;
        $display("FAIL %s_run cyc=%0d got busy=%b done=%b res=%h want 1 0 %h", nm, i, busy8, done8, {cout8, sum8}, hold8);
      end
      tick;
    end
    total++;
    if (busy8 !== 0 || done8 !== 1 || {cout8, sum8} !== e) begin
      bad++;
      $display("FAIL %s_done got busy=%b done=%b res=%h want 0 1 %h", nm, busy8, done8, {cout8, sum8}, e);
    end
    hold8 = e;
    tick;
    total++;
    if (busy8 !== 0 || done8 !== 0 || {cout8, sum8} !== hold8) begin
      bad++;
      $display("FAIL %s_hold got busy=%b done=%b res=%h want 0 0 %h", nm, busy8, done8, {cout8, sum8}, hold8);
    end
  endtask

  task automatic test_carry_chain;
    op8(8'hFF, 8'h01, "carry_chain");
    tick;
    total++;
    if (sum8 !== 8'h00 || cout8 !== 1'b1) begin
      bad++;
      $display("FAIL carry_hold got sum=%h cout=%b want 00 1", sum8, cout8);
    end
  endtask

  task automatic test_patterns;
    op8(8'hA5, 8'h5A, "nocarry");
    op8(8'h80, 8'h80, "msb_carry");
    op8(8'h00, 8'h00, "zeros");
    for (int i = 0; i < 6; i++) op8(8'($urandom), 8'($urandom), "rand8");
  endtask

  task automatic test_start_while_busy;
    a8 = 8'h10;
    b8 = 8'h20;
    st8 = 1;
    tick;
    st8 = 0;
    tick;
    tick;
    a8 = 8'hFF;
    b8 = 8'hFF;
    st8 = 1;
    tick;
    st8 = 0;
    for (int i = 0; i < 5; i++) tick;
    total++;
    if (done8 !== 1 || busy8 !== 0 || {cout8, sum8} !== 9'h030) begin
      bad++;
      $display("FAIL ignore_start got done=%b busy=%b res=%h want 1 0 030", done8, busy8, {cout8, sum8});
    end
    hold8 = 9'h030;
    a8 = 8'h01;
    b8 = 8'h02;
    st8 = 1;
    tick;
    st8 = 0;
    for (int i = 0; i < 7; i++) begin
      total++;
      if (busy8 !== 1 || done8 !== 0 || {cout8, sum8} !== hold8) begin
        bad++;
        $display("FAIL b2b_run cyc=%0d got busy=%b done=%b res=%h want 1 0 %h", i, busy8, done8, {cout8, sum8}, hold8);
      end
      tick;
    end
    tick;
    total++;
    if (done8 !== 1 || busy8 !== 0 || {cout8, sum8} !== 9'h003) begin
      bad++;
      $display("FAIL b2b_done got done=%b busy=%b res=%h want 1 0 003", done8, busy8, {cout8, sum8});
    end
    hold8 = 9'h003;
    tick;
  endtask

  task automatic test_reset_mid;
    a8 = 8'h7F;
    b8 = 8'h01;
    st8 = 1;
    tick;
    st8 = 0;
    tick;
    tick;
    tick;
    rst_n = 0;
    tick;
    rst_n = 1;
    total++;
    if ({busy8, done8, cout8, sum8} !== 11'h0) begin
      bad++;
      $display("FAIL reset_mid got busy=%b done=%b cout=%b sum=%h want all 0", busy8, done8, cout8, sum8);
    end
    hold8 = 0;
    hold16 = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      total++;
      if (done8 !== 0 || busy8 !== 0 || {cout8, sum8} !== 9'h0) begin
        bad++;
        $display("FAIL reset_mid_quiet cyc=%0d got done=%b busy=%b res=%h want 0 0 000", i, done8, busy8, {cout8, sum8});
      end
    end
    op8(8'h7F, 8'h01, "after_reset");
  endtask

  task automatic test_width1;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] e;
      a1 = 1'(i >> 1);
      b1 = 1'(i);
      e = {1'b0, a1} + {1'b0, b1};
      st1 = 1;
      tick;
      st1 = 0;
      total++;
      if (busy1 !== 1 || done1 !== 0) begin
        bad++;
        $display("FAIL w1_run pair=%0d got busy=%b done=%b want 1 0", i, busy1, done1);
      end
      tick;
      total++;
      if (busy1 !== 0 || done1 !== 1 || {cout1, sum1} !== e) begin
        bad++;
        $display("FAIL w1_done pair=%0d got busy=%b done=%b res=%b want 0 1 %b", i, busy1, done1, {cout1, sum1}, e);
      end
      tick;
      total++;
      if (done1 !== 0 || {cout1, sum1} !== e) begin
        bad++;
        $display("FAIL w1_pulse pair=%0d got done=%b res=%b want 0 %b", i, done1, {cout1, sum1}, e);
      end
    end
  endtask

  task automatic test_width16;
    for (int n = 0; n < 20; n++) begin
      logic [16:0] e;
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      e = {1'b0, a16} + {1'b0, b16};
      st16 = 1;
      tick;
      st16 = 0;
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      for (int i = 0; i < 16; i++) begin
        if (busy16 !== 1 || done16 !== 0 || {cout16, sum16} !== hold16) begin
          total++;
          bad++;
          $display("FAIL w16_run op=%0d cyc=%0d got busy=%b done=%b res=%h want 1 0 %h", n, i, busy16, done16, {cout16, sum16}, hold16);
        end
        tick;
      end
      total++;
      if (busy16 !== 0 || done16 !== 1 || {cout16, sum16} !== e) begin
        bad++;
        $display("FAIL w16_done op=%0d got busy=%b done=%b res=%h want 0 1 %h", n, busy16, done16, {cout16, sum16}, e);
      end
      hold16 = e;
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_carry_chain;
    test_patterns;
    test_start_while_busy;
    test_reset_mid;
    test_width1;
    test_width16;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
